// File: rtl/rv32i_types.sv
// Shared types for the CPU-to-physical-memory port adapter: FSM states and load width codes.
package rv32i_types;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mem_port_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

endpackage

// File: rtl/mem_port_adapter_if.sv
// CPU-side and physical-memory-side signals of the port adapter.
// The slave modport is the adapter; the master modport is the CPU/memory environment.
interface mem_port_adapter_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [2:0]  funct3;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_wdata;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, funct3,
        input  pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata, mem_error,
        output pmem_read, pmem_write, pmem_address, pmem_wmask, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, funct3,
        output pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata, mem_error,
        input  pmem_read, pmem_write, pmem_address, pmem_wmask, pmem_wdata
    );
endinterface

// File: rtl/load_extend.sv
// Aligns a raw memory word to the byte offset and sign/zero-extends it per the load code.
module load_extend
    import rv32i_types::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        case (load_funct3_t'(funct3_i))
            lb:      data_o = {{24{shifted[7]}}, shifted[7:0]};
            lh:      data_o = {{16{shifted[15]}}, shifted[15:0]};
            lbu:     data_o = {24'd0, shifted[7:0]};
            lhu:     data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/mem_port_adapter.sv
// Adapts a held CPU load/store request to a word-addressed physical memory port.
// Optional watchdog on the memory response is enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_adapter
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_adapter_if.slave bus
);
    mem_port_state_t state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wmask_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        write_q;
    logic [31:0] ext_word;
    logic        start, finish, timeout;

    load_extend u_load_extend (
        .word_i   (bus.pmem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (ext_word)
    );

    assign start  = (state_q == StIdle) && (bus.mem_read || bus.mem_write);
    assign finish = (state_q == StBusy) && (bus.pmem_resp || timeout);

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == StBusy) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            // A response arriving in the timeout cycle still counts as success.
            if (finish) begin
                err_q <= !bus.pmem_resp;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.mem_read || bus.mem_write) state_d = StBusy;
            StBusy:  if (bus.pmem_resp || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= {bus.mem_address[31:2], 2'b00};
                off_q   <= bus.mem_address[1:0];
                f3_q    <= bus.funct3;
                write_q <= bus.mem_write;
                wmask_q <= bus.mem_byte_enable << bus.mem_address[1:0];
                wdata_q <= bus.mem_wdata << {bus.mem_address[1:0], 3'b000};
            end
            if (finish) begin
                rdata_q <= (bus.pmem_resp && !write_q) ? ext_word : 32'd0;
            end
        end
    end

    always_comb begin
        bus.mem_resp     = (state_q == StDone);
        bus.mem_rdata    = (state_q == StDone) ? rdata_q : 32'd0;
        bus.pmem_read    = (state_q == StBusy) && !write_q;
        bus.pmem_write   = (state_q == StBusy) && write_q;
        bus.pmem_address = addr_q;
        bus.pmem_wmask   = wmask_q;
        bus.pmem_wdata   = wdata_q;
`ifdef MEM_PORT_TIMEOUT_EN
        bus.mem_error    = (state_q == StDone) && err_q;
`else
        bus.mem_error    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_mem_port_adapter.sv
// Randomized bench for mem_port_adapter against a lane/extension reference model.
module tb_mem_port_adapter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_adapter_if bus ();

    mem_port_adapter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] off, logic [2:0] f3);
        logic [31:0] s;
        s = word >> (8 * off);
        case (f3)
            3'b000:  return ((s & 32'hFF) ^ 32'h80) - 32'h80;
            3'b001:  return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'b100:  return s & 32'hFF;
            3'b101:  return s & 32'hFFFF;
            default: return s;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        bus.funct3          = '0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_resp"}, 32'(bus.mem_resp), 32'd0);
        check({tag, "_rd"}, 32'(bus.pmem_read), 32'd0);
        check({tag, "_wr"}, 32'(bus.pmem_write), 32'd0);
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] rdw, input int dly);
        logic [31:0] exp_mask, exp_wdata, exp_rdata;
        logic [1:0]  off;
        off       = addr[1:0];
        exp_mask  = ({28'd0, be} << off) & 32'hF;
        exp_wdata = wd << (8 * off);
        exp_rdata = wr ? 32'd0 : model_load(rdw, off, f3);

        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        bus.funct3          = f3;
        tick();
        check("busy_rd", 32'(bus.pmem_read), 32'(!wr));
        check("busy_wr", 32'(bus.pmem_write), 32'(wr));
        check("paddr", bus.pmem_address, addr & 32'hFFFF_FFFC);
        if (wr) begin
            check("wmask", 32'(bus.pmem_wmask), exp_mask);
            check("wdata", bus.pmem_wdata, exp_wdata);
        end
        // Request stays held but its payload changes; captured values must not.
        bus.mem_address     = $urandom;
        bus.mem_byte_enable = 4'($urandom);
        bus.mem_wdata       = $urandom;
        bus.funct3          = 3'($urandom);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("hold_strobe", 32'(bus.pmem_read | bus.pmem_write), 32'd1);
            check("hold_resp", 32'(bus.mem_resp), 32'd0);
            check("hold_paddr", bus.pmem_address, addr & 32'hFFFF_FFFC);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdw;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = $urandom;
        check("done_resp", 32'(bus.mem_resp), 32'd1);
        check("done_rdata", bus.mem_rdata, exp_rdata);
        check("done_err", 32'(bus.mem_error), 32'd0);
        check("done_strobe", 32'(bus.pmem_read | bus.pmem_write), 32'd0);
        tick();
        check_quiet("gap");
        idle_inputs();
    endtask

    initial begin
        logic [3:0] bes [3];
        int         kind;
        bes[0] = 4'b0001;
        bes[1] = 4'b0011;
        bes[2] = 4'b1111;
        idle_inputs();
        repeat (2) tick();
        check_quiet("rst");
        check("rst_err", 32'(bus.mem_error), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_paddr", bus.pmem_address, 32'd0);
        check("rst_wmask", 32'(bus.pmem_wmask), 32'd0);
        check("rst_wdata", bus.pmem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        run_txn(1'b1, 1'b0, 32'h103, 4'b0001, 32'd0, 3'b100, 32'hAB11_2233, 0);
        run_txn(1'b1, 1'b0, 32'h102, 4'b0011, 32'd0, 3'b001, 32'h80FF_0000, 1);
        run_txn(1'b0, 1'b1, 32'h201, 4'b0001, 32'h0000_00C5, 3'b000, 32'h1234_5678, 2);
        run_txn(1'b1, 1'b0, 32'h40, 4'b1111, 32'd0, 3'b010, 32'h1234_5678, 5);
        run_txn(1'b0, 1'b1, 32'h12, 4'b1111, 32'hDEAD_BEEF, 3'b010, 32'd0, 0);
        run_txn(1'b1, 1'b1, 32'h33, 4'b0011, 32'hCAFE_F00D, 3'b001, 32'hFFFF_FFFF, 1);

        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, kind != 0, $urandom, bes[$urandom_range(0, 2)], $urandom,
                    3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 5)));
        end

        // Reset in the middle of a read abandons it; a stray response is ignored.
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h300;
        bus.funct3      = 3'b010;
        tick();
        check("pre_rst_rd", 32'(bus.pmem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_quiet("mid_rst");
        check("mid_rst_paddr", bus.pmem_address, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 32'h5555_AAAA;
        tick();
        bus.pmem_resp = 1'b0;
        check_quiet("post_rst1");
        tick();
        check_quiet("post_rst2");

`ifdef MEM_PORT_TIMEOUT_EN
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h600;
        bus.funct3      = 3'b010;
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            check("to_busy", 32'(bus.pmem_read), 32'd1);
            check("to_noresp", 32'(bus.mem_resp), 32'd0);
            tick();
        end
        check("to_resp", 32'(bus.mem_resp), 32'd1);
        check("to_err", 32'(bus.mem_error), 32'd1);
        check("to_rdata", bus.mem_rdata, 32'd0);
        check("to_strobe", 32'(bus.pmem_read), 32'd0);
        idle_inputs();
        tick();
        check_quiet("to_after");
        check("to_err_after", 32'(bus.mem_error), 32'd0);
        // Response in the same cycle the watchdog expires must win.
        run_txn(1'b1, 1'b0, 32'h700, 4'b1111, 32'd0, 3'b010, 32'h0BAD_F00D, int'(TO) - 1);
`else
        run_txn(1'b1, 1'b0, 32'h500, 4'b1111, 32'd0, 3'b010, 32'h0BAD_F00D, 40);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
